// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the pipelined carry-lookahead adder.
//   GROUP_W / SECT_W  : nibble group width and lookahead section width
//   pg_t              : propagate/generate pair for one nibble group
//   grp_pg()          : nibble P/G from the four bit-level p/g pairs
//   bit_carries()     : carries into the four bits of a nibble, given the
//                       nibble's incoming carry (two-level expansion, no ripple)
// -----------------------------------------------------------------------------
package cla_pkg;

    localparam int GROUP_W = 4;
    localparam int SECT_W  = 16;
    localparam int NIB_PER_SECT = SECT_W / GROUP_W;

    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    function automatic pg_t grp_pg(input logic [3:0] p4, input logic [3:0] g4);
        pg_t r;
        r.p = &p4;
        r.g = g4[3]
            | (p4[3] & g4[2])
            | (p4[3] & p4[2] & g4[1])
            | (p4[3] & p4[2] & p4[1] & g4[0]);
        return r;
    endfunction

    // Only the low three bit p/g matter: bit 3's pair affects the carry out
    // of the nibble, which the lookahead unit resolves instead.
    function automatic logic [3:0] bit_carries(input logic [2:0] p3,
                                               input logic [2:0] g3,
                                               input logic       c);
        logic [3:0] r;
        r[0] = c;
        r[1] = g3[0] | (p3[0] & c);
        r[2] = g3[1] | (p3[1] & g3[0]) | (p3[1] & p3[0] & c);
        r[3] = g3[2] | (p3[2] & g3[1]) | (p3[2] & p3[1] & g3[0])
             | (p3[2] & p3[1] & p3[0] & c);
        return r;
    endfunction

endpackage

// File: rtl/cla_lookahead4.sv
// -----------------------------------------------------------------------------
// cla_lookahead4
// Lookahead carry unit for one 16-bit section: turns four nibble-group P/G
// pairs and the section carry-in into the carries entering nibbles 1..3, the
// section carry-out, and the section-level group P/G.
// Ports:
//   p[3:0], g[3:0]  in   nibble group propagate / generate
//   cin             in   carry into nibble 0
//   c[3:1]          out  carries into nibbles 1..3
//   cout            out  carry out of nibble 3
//   grp_p, grp_g    out  section propagate / generate
// -----------------------------------------------------------------------------
module cla_lookahead4
    import cla_pkg::*;
(
    input  logic [3:0] p,
    input  logic [3:0] g,
    input  logic       cin,
    output logic [3:1] c,
    output logic       cout,
    output logic       grp_p,
    output logic       grp_g
);

    pg_t w_sect;

    // Nibble-level and section-level P/G share the same 4-term form.
    assign w_sect = grp_pg(p, g);
    assign grp_p  = w_sect.p;
    assign grp_g  = w_sect.g;

    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign cout = grp_g | (grp_p & cin);

endmodule

// File: rtl/cla_pipe_adder.sv
// -----------------------------------------------------------------------------
// cla_pipe_adder
// Two-stage pipelined WIDTH-bit carry-lookahead adder with valid/ready on both
// sides. Final carry-propagate adder of the Booth-Wallace multiplier.
//   S1 registers bit p/g and carry-in; S2 resolves nibble carries with one
//   lookahead unit per 16-bit section (sections ripple combinationally) and
//   registers sum / cout / ovf.
// Parameters:
//   WIDTH      operand width, multiple of 16 in 16..64
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid / in_ready  operand handshake
//   a, b, cin            operands and carry-in
//   sub                  subtract request (used only with CLA_PIPE_SUB_EN)
//   out_valid/out_ready  result handshake
//   sum, cout, ovf       a+b+cin mod 2^WIDTH, carry out, signed overflow
// Build option:
//   CLA_PIPE_SUB_EN  when defined, sub=1 makes the beat compute a-b
//                    (cout=1 means no borrow); otherwise sub is ignored.
// -----------------------------------------------------------------------------
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSECT = WIDTH / SECT_W;

    logic             r_run;
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_p;
    logic [WIDTH-1:0] r_s1_g;
    logic             r_s1_cin;

    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;
    logic             w_s2_adv;
    logic [WIDTH-1:0] w_carry;
    logic             w_cout_top;

    // ---------------- operand conditioning ----------------
`ifdef CLA_PIPE_SUB_EN
    // Two's-complement subtract: invert b and force the +1 through cin.
    assign w_b_eff   = b ^ {WIDTH{sub}};
    assign w_cin_eff = cin | sub;
`else
    logic w_unused_sub;
    assign w_b_eff      = b;
    assign w_cin_eff    = cin;
    assign w_unused_sub = sub;
`endif

    // ---------------- handshake ----------------
    // r_run keeps the input closed while reset is held and opens it on the
    // first edge after release.
    assign w_s2_adv = !out_valid | out_ready;
    assign in_ready = r_run & (!r_s1_valid | w_s2_adv);

    // ---------------- stage S1 ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_run      <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_p     <= '0;
            r_s1_g     <= '0;
            r_s1_cin   <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (in_ready) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_p   <= a ^ w_b_eff;
                    r_s1_g   <= a & w_b_eff;
                    r_s1_cin <= w_cin_eff;
                end
            end
        end
    end

    // ---------------- stage S2 carry network ----------------
    genvar gi, gj;
    generate
        for (gi = 0; gi < NSECT; gi++) begin : g_sect
            logic       w_cin;
            logic       w_cout;
            logic [3:0] w_np;
            logic [3:0] w_ng;
            logic [3:1] w_nc_hi;
            logic [3:0] w_nc;
            // Section P/G would feed a second-level lookahead; sections
            // ripple here instead, so they are left unconsumed.
            logic       w_unused_grp_p;
            logic       w_unused_grp_g;

            // Each section has its own carry signals so the inter-section
            // chain is a plain wire-to-wire path, not a self-referencing vector.
            if (gi == 0) begin : g_first
                assign w_cin = r_s1_cin;
            end else begin : g_chain
                assign w_cin = g_sect[gi-1].w_cout;
            end

            for (gj = 0; gj < NIB_PER_SECT; gj++) begin : g_nib
                localparam int LSB = gi * SECT_W + gj * GROUP_W;
                pg_t w_pg;
                assign w_pg     = grp_pg(r_s1_p[LSB +: GROUP_W], r_s1_g[LSB +: GROUP_W]);
                assign w_np[gj] = w_pg.p;
                assign w_ng[gj] = w_pg.g;
                assign w_carry[LSB +: GROUP_W] =
                    bit_carries(r_s1_p[LSB +: 3], r_s1_g[LSB +: 3], w_nc[gj]);
            end

            cla_lookahead4 u_la (
                .p     (w_np),
                .g     (w_ng),
                .cin   (w_cin),
                .c     (w_nc_hi),
                .cout  (w_cout),
                .grp_p (w_unused_grp_p),
                .grp_g (w_unused_grp_g)
            );

            assign w_nc = {w_nc_hi, w_cin};
        end
    endgenerate

    assign w_cout_top = g_sect[NSECT-1].w_cout;

    // ---------------- stage S2 register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (w_s2_adv) begin
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                sum  <= r_s1_p ^ w_carry;
                cout <= w_cout_top;
                // Overflow: carry into the sign bit differs from carry out of it.
                ovf  <= w_cout_top ^ w_carry[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_cla_pipe_adder
// Directed bench for cla_pipe_adder: a WIDTH=16 instance driven from a table
// of hand-computed vectors (latency, back-pressure burst, reset flush) and a
// WIDTH=64 instance for the cross-section ripple case plus a few random beats.
// -----------------------------------------------------------------------------
module tb_cla_pipe_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // WIDTH=16 instance
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [15:0] a, b, sum;

    // WIDTH=64 instance
    logic        in_valid64, in_ready64, cin64, sub64, out_valid64, out_ready64, cout64, ovf64;
    logic [63:0] a64, b64, sum64;

    cla_pipe_adder #(.WIDTH(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    cla_pipe_adder #(.WIDTH(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid64), .in_ready(in_ready64),
        .a(a64), .b(b64), .cin(cin64), .sub(sub64), .out_valid(out_valid64),
        .out_ready(out_ready64), .sum(sum64), .cout(cout64), .ovf(ovf64)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [15:0] a, b, s;
        logic        cin, sub, co, ov;
    } vec_t;

    vec_t        vecs [12];
    logic [17:0] exp_q [$];   // {ovf, cout, sum} in acceptance order
    bit          mon_en;
    bit          saw_in_ready_low;

    task automatic setv(input int i, input logic [15:0] va, input logic [15:0] vb,
                        input logic vc, input logic vs,
                        input logic [15:0] es, input logic eco, input logic eov);
        vecs[i].a = va;  vecs[i].b = vb;  vecs[i].cin = vc; vecs[i].sub = vs;
        vecs[i].s = es;  vecs[i].co = eco; vecs[i].ov = eov;
    endtask

    // Called just after a negedge; returns at the negedge after acceptance.
    task automatic send(input int i);
        int guard;
        guard    = 0;
        a        = vecs[i].a;
        b        = vecs[i].b;
        cin      = vecs[i].cin;
        sub      = vecs[i].sub;
        in_valid = 1'b1;
        #1;
        while (!in_ready && guard < 50) begin
            saw_in_ready_low = 1'b1;
            @(negedge clk);
            #1;
            guard++;
        end
        if (!in_ready) check("accept_timeout", 64'd0, 64'd1);
        else begin
            exp_q.push_back({vecs[i].ov, vecs[i].co, vecs[i].s});
            $display("beat %0d: a=%h b=%h cin=%b sub=%b -> exp sum=%h cout=%b ovf=%b",
                     i, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                     vecs[i].s, vecs[i].co, vecs[i].ov);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run64(input logic [63:0] va, input logic [63:0] vb, input logic vc);
        logic [64:0] full;
        logic        eov;
        int          g;
        full = {1'b0, va} + {1'b0, vb} + {64'd0, vc};
        eov  = (va[63] == vb[63]) && (full[63] != va[63]);
        check("in_ready64", 64'(in_ready64), 64'd1);
        a64 = va; b64 = vb; cin64 = vc; in_valid64 = 1'b1;
        @(negedge clk);
        in_valid64 = 1'b0;
        g = 0;
        while (!out_valid64 && g < 10) begin
            @(negedge clk);
            g++;
        end
        check("out_valid64", 64'(out_valid64), 64'd1);
        check("sum64",  sum64,         full[63:0]);
        check("cout64", 64'(cout64),   64'(full[64]));
        check("ovf64",  64'(ovf64),    64'(eov));
        $display("beat64: a=%h b=%h cin=%b -> sum=%h cout=%b ovf=%b", va, vb, vc, sum64, cout64, ovf64);
        @(negedge clk);
    endtask

    // Result monitor: compares the head of the queue every cycle out_valid is
    // high (so held values are re-checked while stalled) and pops on transfer.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en && out_valid) begin
                if (exp_q.size() == 0) check("unexpected_out", 64'd1, 64'd0);
                else begin
                    check("sum",  64'(sum),  64'(exp_q[0][15:0]));
                    check("cout", 64'(cout), 64'(exp_q[0][16]));
                    check("ovf",  64'(ovf),  64'(exp_q[0][17]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //    idx  a        b        cin   sub   sum      cout  ovf
        setv(0,  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        setv(1,  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        setv(2,  16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        setv(3,  16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
        setv(4,  16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
        setv(5,  16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        setv(6,  16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        setv(7,  16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0);
        setv(8,  16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);
`ifdef CLA_PIPE_SUB_EN
        setv(9,  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        setv(11, 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
`else
        setv(9,  16'h0005, 16'h0007, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b0);
        setv(11, 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b0);
`endif
        setv(10, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

        rst_n = 1'b0; mon_en = 1'b1; saw_in_ready_low = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        in_valid64 = 1'b0; out_ready64 = 1'b1; a64 = '0; b64 = '0; cin64 = 1'b0; sub64 = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum",       64'(sum),       64'd0);
        check("rst_cout",      64'(cout),      64'd0);
        check("rst_ovf",       64'(ovf),       64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", 64'(in_ready), 64'd1);

        // Two-cycle latency on a single beat.
        send(0);
        in_valid = 1'b0;
        check("lat_cycle1_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("lat_cycle2_valid", 64'(out_valid), 64'd1);
        drain();

        // Back-to-back burst with a three-cycle downstream stall.
        fork
            begin
                for (int i = 1; i <= 8; i++) send(i);
                in_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 12; k++) begin
                    @(negedge clk);
                    out_ready = !(k >= 3 && k <= 5);
                end
            end
        join
        out_ready = 1'b1;
        drain();
        check("burst_in_ready_dropped", 64'(saw_in_ready_low), 64'd1);

        // Subtract / plain vectors.
        send(9);
        send(10);
        send(11);
        in_valid = 1'b0;
        drain();

        // Reset with two beats in flight.
        out_ready = 1'b0;
        send(2);
        send(3);
        in_valid = 1'b0;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_sum",       64'(sum),       64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        mon_en    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("no_stale_out", 64'(out_valid), 64'd0);
        end
        send(4);
        in_valid = 1'b0;
        drain();

        // WIDTH=64: ripple across section boundaries, then random beats.
        run64(64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        check("sum64_ripple_const", sum64, 64'h0001_0000_0000_0000);
        run64(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
        for (int k = 0; k < 20; k++)
            run64({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
